io_bridge: RTL and testbench

- Memory-mapped bus bridge directly downstream of the pipelined CPU's data-bus port (Bus_addr/Bus_we/Bus_wdata/Bus_rdata).
- Splits each access between the data RAM (DRAM) and an on-board peripheral set: 7-segment display, LEDs, switches, buttons and a programmable timer.
- Read data returns combinationally in the same cycle; the CPU's MEM stage and forwarding logic depend on zero-wait reads. Writes commit at the clock edge.

---
 rtl/io_bridge_pkg.sv | 63 ++++++
 rtl/io_bridge_seg7_scan.sv | 47 ++++
 rtl/io_bridge.sv | 137 +++++++++++++
 tb/tb_io_bridge.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared constants, register map and segment codes for the CPU-side I/O bridge.
package io_bridge_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DRAM_AW = 14;
    localparam int unsigned LED_W   = 24;
    localparam int unsigned SW_W    = 24;
    localparam int unsigned BTN_W   = 5;
    localparam int unsigned DIG_N   = 8;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned OFF_W   = 12;

    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

    localparam logic [OFF_W-1:0] OFF_DIG  = 12'h000;
    localparam logic [OFF_W-1:0] OFF_TCNT = 12'h020;
    localparam logic [OFF_W-1:0] OFF_TDIV = 12'h024;
    localparam logic [OFF_W-1:0] OFF_LED  = 12'h060;
    localparam logic [OFF_W-1:0] OFF_SW   = 12'h070;
    localparam logic [OFF_W-1:0] OFF_BTN  = 12'h078;

    // Active-low {DP,G,F,E,D,C,B,A}, DP always off.
    localparam logic [SEG_W-1:0] SEG_CODE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [2:0] {
        REG_NONE,
        REG_DIG,
        REG_TCNT,
        REG_TDIV,
        REG_LED,
        REG_SW,
        REG_BTN
    } reg_sel_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic reg_sel_e decode_off(input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] word_off;
        word_off = {off[OFF_W-1:2], 2'b00};
        case (word_off)
            OFF_DIG:  decode_off = REG_DIG;
            OFF_TCNT: decode_off = REG_TCNT;
            OFF_TDIV: decode_off = REG_TDIV;
            OFF_LED:  decode_off = REG_LED;
            OFF_SW:   decode_off = REG_SW;
            OFF_BTN:  decode_off = REG_BTN;
            default:  decode_off = REG_NONE;
        endcase
    endfunction

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] hex);
        hex_to_seg = SEG_CODE[hex];
    endfunction

endpackage

// File: rtl/io_bridge_seg7_scan.sv
// Multiplexed 8-digit 7-segment scanner: rotates the lit digit every SCAN_DIV cycles.
module seg7_scan
    import io_bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    input  logic [DATA_W-1:0]      dig,
    output logic [DIG_N-1:0]       dig_en,
    output logic [SEG_W-1:0]       dig_seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = 3;

    logic [CNT_W-1:0] scan_q, scan_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       nib_c;

    always_comb begin
        scan_d = scan_q + CNT_W'(1);
        idx_d  = idx_q;
        if (scan_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else begin
            scan_q <= scan_d;
            idx_q  <= idx_d;
        end
    end

    // Decoded straight from flops so a DIG write shows the cycle after its edge.
    always_comb begin
        nib_c   = dig[4*idx_q +: 4];
        dig_en  = ~(DIG_N'(1) << idx_q);
        dig_seg = hex_to_seg(nib_c);
    end

endmodule

// File: rtl/io_bridge.sv
// Data-bus bridge: splits CPU accesses between DRAM and the board peripherals
// (display, LEDs, switches, buttons, timer) with zero-wait combinational reads.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned       SCAN_DIV = 20000,
    parameter logic [DATA_W-1:0] TDIV_RST = 32'd0
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic [ADDR_W-1:0]   Bus_addr,
    input  logic                Bus_we,
    input  logic [DATA_W-1:0]   Bus_wdata,
    output logic [DATA_W-1:0]   Bus_rdata,
    output logic [DRAM_AW-1:0]  dram_addr,
    output logic                dram_we,
    output logic [DATA_W-1:0]   dram_wdata,
    input  logic [DATA_W-1:0]   dram_rdata,
    input  logic [SW_W-1:0]     sw,
    input  logic [BTN_W-1:0]    btn,
    output logic [LED_W-1:0]    led,
    output logic [DIG_N-1:0]    dig_en,
    output logic [SEG_W-1:0]    dig_seg
);

    bus_req_t    req_c;
    logic        periph_c;
    reg_sel_e    sel_c;
    logic        unused_addr_lsb;

    logic [DATA_W-1:0] dig_q, dig_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [DATA_W-1:0] tcnt_q, tcnt_d;
    logic [DATA_W-1:0] tdiv_q, tdiv_d;
    logic [DATA_W-1:0] presc_q, presc_d;
    logic [SW_W-1:0]   sw_meta_q, sw_s_q;
    logic [BTN_W-1:0]  btn_meta_q, btn_s_q;

    assign req_c           = '{addr: Bus_addr, we: Bus_we, wdata: Bus_wdata};
    assign unused_addr_lsb = ^req_c.addr[1:0];

    // Address decode and DRAM side.
    always_comb begin
        periph_c   = (req_c.addr[31:12] == PERIPH_BASE);
        sel_c      = periph_c ? decode_off(req_c.addr[OFF_W-1:0]) : REG_NONE;
        dram_addr  = req_c.addr[15:2];
        dram_wdata = req_c.wdata;
        dram_we    = req_c.we & ~periph_c;
    end

    // Zero-wait read mux.
    always_comb begin
        Bus_rdata = dram_rdata;
        if (periph_c) begin
            case (sel_c)
                REG_DIG:  Bus_rdata = dig_q;
                REG_TCNT: Bus_rdata = tcnt_q;
                REG_TDIV: Bus_rdata = tdiv_q;
                REG_LED:  Bus_rdata = {8'b0, led_q};
                REG_SW:   Bus_rdata = {8'b0, sw_s_q};
                REG_BTN:  Bus_rdata = {27'b0, btn_s_q};
                default:  Bus_rdata = '0;
            endcase
        end
    end

    // Register writes and timer; bus writes to TCNT/TDIV override the tick.
    always_comb begin
        dig_d   = dig_q;
        led_d   = led_q;
        tcnt_d  = tcnt_q;
        tdiv_d  = tdiv_q;
        presc_d = presc_q;

        if (tdiv_q != '0) begin
            if (presc_q == DATA_W'(tdiv_q - 32'd1)) begin
                presc_d = '0;
                tcnt_d  = tcnt_q + DATA_W'(1);
            end else begin
                presc_d = presc_q + DATA_W'(1);
            end
        end

        if (req_c.we) begin
            case (sel_c)
                REG_DIG:  dig_d = req_c.wdata;
                REG_LED:  led_d = req_c.wdata[LED_W-1:0];
                REG_TCNT: begin
                    tcnt_d  = req_c.wdata;
                    presc_d = '0;
                end
                REG_TDIV: begin
                    tdiv_d  = req_c.wdata;
                    presc_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            dig_q      <= '0;
            led_q      <= '0;
            tcnt_q     <= '0;
            tdiv_q     <= TDIV_RST;
            presc_q    <= '0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            btn_meta_q <= '0;
            btn_s_q    <= '0;
        end else begin
            dig_q      <= dig_d;
            led_q      <= led_d;
            tcnt_q     <= tcnt_d;
            tdiv_q     <= tdiv_d;
            presc_q    <= presc_d;
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
        end
    end

    assign led = led_q;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .dig     (dig_q),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge with a behavioural DRAM and hand-computed expectations.
module tb_io_bridge;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_we;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] dram_mem [0:16383];

    io_bridge #(
        .SCAN_DIV (2),
        .TDIV_RST (32'd0)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_we     (Bus_we),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_we    (dram_we),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    assign dram_rdata = dram_mem[dram_addr];
    always @(posedge cpu_clk) begin
        if (dram_we) dram_mem[dram_addr] <= dram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        Bus_addr  = addr;
        Bus_we    = we;
        Bus_wdata = wdata;
        #1;
    endtask

    initial begin
        logic [7:0] exp_en;
        logic [7:0] exp_seg;
        int         idx;

        cpu_rst = 1'b1;
        sw      = '0;
        btn     = '0;
        bus(32'h0, 1'b0, 32'h0);
        step(2);

        // Reset state, then display scan with DIG=0x8F written in the first free cycle.
        cpu_rst = 1'b0;
        bus(32'hFFFFF020, 1'b0, 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_dig_en", 32'(dig_en), 32'hFE);
        chk("rst_dig_seg", 32'(dig_seg), 32'hC0);
        chk("rst_tcnt", Bus_rdata, 32'h0);
        bus(32'hFFFFF000, 1'b1, 32'h0000008F);
        step(1);
        bus(32'hFFFFF000, 1'b0, 32'h0);
        chk("dig_read", Bus_rdata, 32'h0000008F);
        for (int c = 1; c <= 17; c++) begin
            idx     = (c / 2) % 8;
            exp_en  = ~(8'h01 << idx);
            exp_seg = (idx == 0) ? 8'h8E : (idx == 1) ? 8'h80 : 8'hC0;
            chk($sformatf("scan_en_c%0d", c), 32'(dig_en), 32'(exp_en));
            chk($sformatf("scan_seg_c%0d", c), 32'(dig_seg), 32'(exp_seg));
            step(1);
        end

        // DRAM write/read.
        bus(32'h00000100, 1'b1, 32'h12345678);
        chk("dram_we_wr", 32'(dram_we), 32'h1);
        chk("dram_addr", 32'(dram_addr), 32'h040);
        chk("dram_wdata", dram_wdata, 32'h12345678);
        step(1);
        bus(32'h00000100, 1'b0, 32'h0);
        chk("dram_we_rd", 32'(dram_we), 32'h0);
        chk("dram_rdata", Bus_rdata, 32'h12345678);

        // LED write stays off DRAM.
        bus(32'hFFFFF060, 1'b1, 32'h00ABCDEF);
        chk("led_dram_we", 32'(dram_we), 32'h0);
        step(1);
        bus(32'hFFFFF060, 1'b0, 32'h0);
        chk("led_out", 32'(led), 32'hABCDEF);
        chk("led_read", Bus_rdata, 32'h00ABCDEF);
        bus(32'hFFFFF062, 1'b0, 32'h0);
        chk("led_read_lsb_ign", Bus_rdata, 32'h00ABCDEF);

        // Unmapped peripheral offset.
        bus(32'hFFFFF100, 1'b1, 32'hDEADBEEF);
        chk("unmap_dram_we", 32'(dram_we), 32'h0);
        step(1);
        bus(32'hFFFFF100, 1'b0, 32'h0);
        chk("unmap_read", Bus_rdata, 32'h0);

        // Switch and button synchronizers: two-cycle lag.
        sw  = 24'h00F00F;
        btn = 5'h15;
        bus(32'hFFFFF070, 1'b0, 32'h0);
        chk("sw_c0", Bus_rdata, 32'h0);
        step(1);
        chk("sw_c1", Bus_rdata, 32'h0);
        step(1);
        chk("sw_c2", Bus_rdata, 32'h0000F00F);
        bus(32'hFFFFF078, 1'b0, 32'h0);
        chk("btn_c2", Bus_rdata, 32'h00000015);

        // Timer: TDIV=3, TCNT=0xFFFFFFFE wraps.
        bus(32'hFFFFF024, 1'b1, 32'd3);
        step(1);
        bus(32'hFFFFF024, 1'b0, 32'h0);
        chk("tdiv_read", Bus_rdata, 32'd3);
        bus(32'hFFFFF020, 1'b1, 32'hFFFFFFFE);
        step(1);
        bus(32'hFFFFF020, 1'b0, 32'h0);
        chk("tcnt_c0", Bus_rdata, 32'hFFFFFFFE);
        step(2);
        chk("tcnt_c2", Bus_rdata, 32'hFFFFFFFE);
        step(1);
        chk("tcnt_c3", Bus_rdata, 32'hFFFFFFFF);
        step(3);
        chk("tcnt_c6", Bus_rdata, 32'h00000000);
        step(2);
        // Cycle 8 is an increment cycle: the write must win.
        bus(32'hFFFFF020, 1'b1, 32'h00000100);
        step(1);
        bus(32'hFFFFF020, 1'b0, 32'h0);
        chk("tcnt_wr_beats_inc", Bus_rdata, 32'h00000100);
        step(2);
        chk("tcnt_after_wr_c2", Bus_rdata, 32'h00000100);
        step(1);
        chk("tcnt_after_wr_c3", Bus_rdata, 32'h00000101);

        // TDIV=0 halts the count.
        bus(32'hFFFFF024, 1'b1, 32'd0);
        step(1);
        bus(32'hFFFFF020, 1'b0, 32'h0);
        step(10);
        chk("tcnt_halt", Bus_rdata, 32'h00000101);

        // Reset with a same-cycle LED write.
        cpu_rst = 1'b1;
        bus(32'hFFFFF060, 1'b1, 32'h00123456);
        step(1);
        chk("rst2_led", 32'(led), 32'h0);
        chk("rst2_dig_en", 32'(dig_en), 32'hFE);
        chk("rst2_dig_seg", 32'(dig_seg), 32'hC0);
        step(1);
        chk("rst2_led_hold", 32'(led), 32'h0);
        bus(32'hFFFFF020, 1'b0, 32'h0);
        chk("rst2_tcnt", Bus_rdata, 32'h0);
        bus(32'hFFFFF070, 1'b0, 32'h0);
        chk("rst2_sw", Bus_rdata, 32'h0);
        cpu_rst = 1'b0;
        bus(32'hFFFFF060, 1'b0, 32'h0);
        step(1);
        chk("post_rst_led", 32'(led), 32'h0);
        chk("post_rst_led_read", Bus_rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
